// File: rtl/effect_dac_tx.sv
// effect_dac_tx: left-justified 3-wire DAC transmitter for the effects chain.
// One pending sample decouples the effect strobe from the serial frame.
module effect_dac_tx #(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [SAMPLE_W-1:0] i_data,
    input  logic                i_mute,
    output logic                o_bclk,
    output logic                o_lrck,
    output logic                o_sdat,
    output logic                o_overrun,
    output logic                o_underrun
);

    localparam int SW = $clog2(2 * SAMPLE_W);
    localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [SW-1:0] HALF     = SW'(SAMPLE_W);
    localparam logic [SW-1:0] LAST     = SW'(2 * SAMPLE_W - 1);

    logic [7:0]          div_cnt;
    logic [SW-1:0]       slot;
    logic [SW-1:0]       nxt;
    logic [SW-1:0]       pos;
    logic [SAMPLE_W-1:0] pend;
    logic [SAMPLE_W-1:0] frame;
    logic [SAMPLE_W-1:0] load_word;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] shifted;
    logic                pend_vld;
    logic                wrap;
    logic                fe;
    logic                load;

    always_comb begin
        wrap = (div_cnt == DIV_LAST);
        fe   = wrap && o_bclk;
        nxt  = (slot == LAST) ? '0 : slot + SW'(1);
        load = fe && (nxt == '0);
        pos  = (nxt >= HALF) ? nxt - HALF : nxt;
        // An empty pending slot repeats the previous frame
        if (i_mute) begin
            load_word = '0;
        end else if (pend_vld) begin
            load_word = pend;
        end else begin
            load_word = frame;
        end
        word    = (nxt == '0) ? load_word : frame;
        shifted = word << pos;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt    <= '0;
            slot       <= '0;
            pend       <= '0;
            pend_vld   <= 1'b0;
            frame      <= '0;
            o_bclk     <= 1'b0;
            o_lrck     <= 1'b0;
            o_sdat     <= 1'b0;
            o_overrun  <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_overrun  <= 1'b0;
            o_underrun <= 1'b0;
            div_cnt    <= wrap ? 8'd0 : div_cnt + 8'd1;
            if (wrap) begin
                o_bclk <= ~o_bclk;
            end
            if (fe) begin
                slot   <= nxt;
                o_lrck <= (nxt >= HALF);
                o_sdat <= shifted[SAMPLE_W-1];
            end
            if (load) begin
                frame      <= load_word;
                o_underrun <= ~pend_vld;
            end
            // A strobe coinciding with a load refills the slot just drained
            if (i_valid) begin
                pend      <= i_data;
                pend_vld  <= 1'b1;
                o_overrun <= pend_vld & ~load;
            end else if (load) begin
                pend_vld <= 1'b0;
            end
        end
    end

endmodule
